// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB4 requester turning single commands into SETUP/ACCESS transfers with one response each.
module apb_cmd_master #(
  parameter int         TIMEOUT   = 16,
  parameter logic [2:0] PPROT_VAL = 3'b010
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [2:0]  PPROT,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic accept, misaligned, done, abort;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign PSEL      = state == SETUP || state == ACCESS;
  assign PENABLE   = state == ACCESS;
  assign PPROT     = PPROT_VAL;
  always_comb begin
    accept     = cmd_valid && state == IDLE;
    misaligned = |cmd_addr[1:0];
    cnt_inc    = &cnt ? cnt : cnt + CW'(1);
    done       = state == ACCESS && PREADY;
    // abort on the TIMEOUT-th consecutive low-PREADY access cycle
    abort      = state == ACCESS && !PREADY && TIMEOUT != 0 && cnt_inc == TLIM;
    state_nxt  = state == IDLE   ? (accept ? (misaligned ? RESP : SETUP) : IDLE) :
                 state == SETUP  ? ACCESS :
                 state == ACCESS ? (done || abort ? RESP : ACCESS) :
                                   (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= state == SETUP ? '0 : (state == ACCESS && !PREADY) ? cnt_inc : cnt;
      if (accept) begin
        rsp_err     <= misaligned;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= '0;
        if (!misaligned) begin
          PADDR  <= cmd_addr;
          PWRITE <= cmd_write;
          PWDATA <= cmd_wdata;
          PSTRB  <= cmd_write ? cmd_strb : 4'b0000;
        end
      end
      if (done || abort) begin
        rsp_err     <= abort || PSLVERR;
        rsp_timeout <= abort;
        rsp_rdata   <= (done && !PWRITE && !PSLVERR) ? PRDATA : '0;
        PWRITE      <= 1'b0;
        PSTRB       <= 4'b0000;
      end
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table, hand-written and random checks of apb_cmd_master against a transaction-level model.
module tb_apb_cmd_master;
  localparam int TO = 16;
  logic        PCLK = 0, PRESETn = 0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_strb = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA = 0;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE, PREADY = 0, PSLVERR = 0;
  logic [3:0]  PSTRB;
  apb_cmd_master #(.TIMEOUT(TO), .PPROT_VAL(3'b010)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  int total = 0, bad = 0;
  logic [31:0] slv_q[$], sb_q[$];
  bit fifo_mode = 0;
  typedef struct {
    bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; int waits; bit perr;
    logic [31:0] prdata; bit e_err; bit e_to; logic [31:0] e_rd; int e_lat; int e_pen;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.addr[1:0] != 2'b00) begin
      r.e_err = 1; r.e_to = 0; r.e_rd = 0; r.e_lat = 1; r.e_pen = 0;
    end else if (TO != 0 && v.waits >= TO) begin
      r.e_err = 1; r.e_to = 1; r.e_rd = 0; r.e_lat = 2 + TO; r.e_pen = TO;
    end else begin
      r.e_err = v.perr; r.e_to = 0; r.e_rd = (!v.wr && !v.perr) ? v.prdata : 0;
      r.e_lat = 3 + v.waits; r.e_pen = v.waits + 1;
    end
    return r;
  endfunction
  task automatic run(input vec_t v, input string tag);
    bit bus_ok = 1, g_err = 0, g_to = 0;
    int cyc = 0, pen = 0, psel = 0, lat = -1;
    logic [31:0] g_rd = 0;
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
    @(posedge PCLK);
    while (lat < 0 && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
      cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_strb = 4'($urandom);
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      if (PSEL) begin
        psel++;
        if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata ||
            PSTRB !== (v.wr ? v.strb : 4'b0000) || PPROT !== 3'b010) bus_ok = 0;
      end
      if (PENABLE) begin
        pen++;
        PREADY = (pen == v.waits + 1);
        if (PREADY) begin
          PSLVERR = v.perr; PRDATA = v.prdata;
          if (fifo_mode && v.addr == 32'h8000_0000) begin
            if (v.wr) slv_q.push_back(PWDATA);
            else PRDATA = slv_q.size() > 0 ? slv_q.pop_front() : 32'h0;
          end
        end
      end
      if (rsp_valid) begin
        lat = cyc; g_err = rsp_err; g_to = rsp_timeout; g_rd = rsp_rdata;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(v.e_lat));
    chk({tag, ".penable_cycles"}, 32'(pen), 32'(v.e_pen));
    chk({tag, ".psel_cycles"}, 32'(psel), 32'(v.e_pen ? v.e_pen + 1 : 0));
    chk({tag, ".bus_stable"}, 32'(bus_ok), 1);
    chk({tag, ".rsp_err"}, 32'(g_err), 32'(v.e_err));
    chk({tag, ".rsp_timeout"}, 32'(g_to), 32'(v.e_to));
    chk({tag, ".rsp_rdata"}, g_rd, v.e_rd);
    if (lat >= 0) begin
      rsp_ready = 1;
      @(posedge PCLK);
      @(negedge PCLK);
      rsp_ready = 0; PREADY = 0;
    end
  endtask
  initial begin
    vec_t tbl[10];
    vec_t v;
    tbl[0] = '{1, 32'h8000_0000, 32'hA5, 4'b0001, 0, 0, 32'h0, 0, 0, 32'h0, 3, 1};
    tbl[1] = '{0, 32'h0000_0000, 32'h0, 4'hF, 3, 0, 32'h5A, 0, 0, 32'h5A, 6, 4};
    tbl[2] = '{1, 32'h0000_FFFC, 32'h1234, 4'hF, 0, 1, 32'h0, 1, 0, 32'h0, 3, 1};
    tbl[3] = '{0, 32'h0000_FFFC, 32'h0, 4'h0, 1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 4, 2};
    tbl[4] = '{0, 32'h0000_0010, 32'h0, 4'h0, 40, 0, 32'h77, 1, 1, 32'h0, 18, 16};
    tbl[5] = '{1, 32'h8000_0000, 32'hCAFE, 4'b1100, 0, 0, 32'h0, 0, 0, 32'h0, 3, 1};
    tbl[6] = '{1, 32'h0000_0002, 32'h99, 4'hF, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0};
    tbl[7] = '{0, 32'h0000_0003, 32'h0, 4'h0, 0, 0, 32'h55, 1, 0, 32'h0, 1, 0};
    tbl[8] = '{0, 32'h0000_0020, 32'h0, 4'h0, 15, 0, 32'h1357_9BDF, 0, 0, 32'h1357_9BDF, 18, 16};
    tbl[9] = '{1, 32'h0000_0024, 32'h42, 4'h3, 16, 0, 32'h0, 1, 1, 32'h0, 18, 16};
    repeat (2) @(negedge PCLK);
    chk("reset.psel", 32'(PSEL), 0);
    chk("reset.penable", 32'(PENABLE), 0);
    chk("reset.pwrite", 32'(PWRITE), 0);
    chk("reset.paddr", PADDR, 0);
    chk("reset.pwdata", PWDATA, 0);
    chk("reset.pstrb", 32'(PSTRB), 0);
    chk("reset.pprot", 32'(PPROT), 32'h2);
    chk("reset.rsp_valid", 32'(rsp_valid), 0);
    chk("reset.rsp_flags", {30'h0, rsp_err, rsp_timeout}, 0);
    chk("reset.rsp_rdata", rsp_rdata, 0);
    chk("reset.cmd_ready", 32'(cmd_ready), 1);
    PRESETn = 1;
    @(negedge PCLK);
    for (int i = 0; i < 10; i++) begin
      run(tbl[i], $sformatf("tbl%0d", i));
      if (i == 0) begin
        chk("idle.paddr_kept", PADDR, 32'h8000_0000);
        chk("idle.pwdata_kept", PWDATA, 32'hA5);
        chk("idle.pwrite_low", 32'(PWRITE), 0);
        chk("idle.pstrb_zero", 32'(PSTRB), 0);
      end
    end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h6; rsp_ready = 0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d.rsp", i), {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'h3);
      chk($sformatf("hold%0d.quiet", i), {29'h0, cmd_ready, PSEL, rsp_timeout}, 0);
      @(negedge PCLK);
    end
    rsp_ready = 1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 0;
    chk("hold.released", {30'h0, rsp_valid, cmd_ready}, 32'h1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8000_0000; cmd_wdata = 32'h11;
    cmd_strb = 4'hF; PREADY = 0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 0;
    @(negedge PCLK);
    chk("rst.in_access", 32'(PENABLE), 1);
    #2 PRESETn = 0;
    #1;
    chk("rst.async_drop", {29'h0, PSEL, PENABLE, rsp_valid}, 0);
    @(negedge PCLK);
    PRESETn = 1;
    @(negedge PCLK);
    chk("rst.after_release", {30'h0, cmd_ready, rsp_valid}, 32'h2);
    fifo_mode = 1;
    for (int i = 0; i < 16; i++) begin
      v.wr = i < 8; v.addr = 32'h8000_0000; v.wdata = v.wr ? $urandom : 32'h0;
      v.strb = 4'hF; v.waits = $urandom_range(0, 2); v.perr = 0;
      if (v.wr) sb_q.push_back(v.wdata);
      v.prdata = v.wr ? 32'h0 : sb_q.pop_front();
      run(model(v), $sformatf("fifo%0d", i));
    end
    fifo_mode = 0;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      v.wr = 1'($urandom);
      v.addr = ($urandom_range(0, 7) == 0) ? a : {a[31:2], 2'b00};
      v.wdata = $urandom; v.strb = 4'($urandom);
      v.waits = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 5);
      v.perr = ($urandom_range(0, 3) == 0); v.prdata = $urandom;
      run(model(v), $sformatf("rnd%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
